// File: rtl/layer1_relu_pack_if.sv
// Bus between the layer-1 MAC array, the ReLU/pack stage and the layer-2 activation buffer.
// sat_cnt_o exists only when RELU_PACK_SAT_CNT_EN is defined.
interface layer1_relu_pack_if #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 6
);
  logic                     start_i;
  logic                     relu_en_i;
  logic signed [ACC_W-1:0]  acc_i;
  logic                     wr_en_o;
  logic [ADDR_W-1:0]        wr_addr_o;
  logic [31:0]              wr_data_o;
  logic                     l2_start_o;
  logic                     busy_o;
  logic                     err_o;
`ifdef RELU_PACK_SAT_CNT_EN
  logic [7:0]               sat_cnt_o;

  modport slave (
    input  start_i, relu_en_i, acc_i,
    output wr_en_o, wr_addr_o, wr_data_o, l2_start_o, busy_o, err_o, sat_cnt_o
  );
  modport master (
    output start_i, relu_en_i, acc_i,
    input  wr_en_o, wr_addr_o, wr_data_o, l2_start_o, busy_o, err_o, sat_cnt_o
  );
`else
  modport slave (
    input  start_i, relu_en_i, acc_i,
    output wr_en_o, wr_addr_o, wr_data_o, l2_start_o, busy_o, err_o
  );
  modport master (
    output start_i, relu_en_i, acc_i,
    input  wr_en_o, wr_addr_o, wr_data_o, l2_start_o, busy_o, err_o
  );
`endif
endinterface

// File: rtl/layer1_relu_pack.sv
// ReLU + requantize layer-1 sums and pack 4 per word into the layer-2 buffer (optional RELU_PACK_SAT_CNT_EN).
// 2 cycles relu_en_i -> wr_en_o; no backpressure, accepts one neuron per cycle while collecting.
module layer1_relu_pack #(
  parameter int NUM_NEURONS = 64,
  parameter int ACC_W       = 32,
  parameter int SHIFT       = 8,
  parameter int ADDR_W      = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  layer1_relu_pack_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, FIRE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_NEURONS - 1);

  state_t              state_q, state_d;
  logic [7:0]          idx_q, idx_d;
  logic [31:0]         pack_q, pack_d;
  logic                pend_q, pend_d;
  logic                pend_last_q, pend_last_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                wr_en_q, wr_en_d;
  logic                wr_last_q, wr_last_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                err_q, err_d;
`ifdef RELU_PACK_SAT_CNT_EN
  logic [7:0]          sat_cnt_q, sat_cnt_d;
`endif

  logic [ACC_W-1:0]    acc_pos;
  logic [ACC_W-1:0]    acc_shr;
  logic [7:0]          act;
  logic                sat;
  logic                busy;
  logic                accept;
  logic                last;
  logic                start_ok;

  always_comb begin
    acc_pos = bus.acc_i[ACC_W-1] ? '0 : bus.acc_i;
    acc_shr = acc_pos >> SHIFT;
    sat     = |acc_shr[ACC_W-1:8];
    act     = sat ? 8'hFF : acc_shr[7:0];
  end

  assign busy     = (state_q == COLLECT) || (state_q == FLUSH);
  assign accept   = bus.relu_en_i && (state_q == COLLECT);
  assign last     = (idx_q == LAST_IDX);
  assign start_ok = bus.start_i && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pack_d      = pack_q;
    pend_d      = 1'b0;
    pend_last_d = pend_last_q;
    pend_addr_d = pend_addr_q;
    wr_en_d     = 1'b0;
    wr_last_d   = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_d       = err_q;
`ifdef RELU_PACK_SAT_CNT_EN
    sat_cnt_d   = sat_cnt_q;
`endif

    case (state_q)
      IDLE:    if (start_ok) state_d = COLLECT;
      COLLECT: if (accept && last) state_d = FLUSH;
      FLUSH:   if (wr_en_q && wr_last_q) state_d = FIRE;
      FIRE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A word completed last cycle goes out now; the pack register restarts
    // empty underneath any lane-0 byte landing in the same cycle.
    if (pend_q) begin
      wr_en_d   = 1'b1;
      wr_last_d = pend_last_q;
      wr_addr_d = pend_addr_q;
      wr_data_d = pack_q;
      pack_d    = '0;
    end

    if (accept) begin
      pack_d[{idx_q[1:0], 3'b000} +: 8] = act;
      idx_d = last ? 8'd0 : idx_q + 8'd1;
      if ((idx_q[1:0] == 2'd3) || last) begin
        pend_d      = 1'b1;
        pend_last_d = last;
        pend_addr_d = ADDR_W'(idx_q[7:2]);
      end
`ifdef RELU_PACK_SAT_CNT_EN
      if (sat && (sat_cnt_q != 8'hFF)) sat_cnt_d = sat_cnt_q + 8'd1;
`endif
    end

    if (start_ok) begin
      idx_d = 8'd0;
      err_d = 1'b0;
`ifdef RELU_PACK_SAT_CNT_EN
      sat_cnt_d = 8'd0;
`endif
    end

    // Any start outside IDLE is dropped, so it is flagged like an overrun.
    if ((bus.relu_en_i && (state_q != COLLECT)) || (bus.start_i && (state_q != IDLE)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= 8'd0;
      pack_q      <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      pend_addr_q <= '0;
      wr_en_q     <= 1'b0;
      wr_last_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_q       <= 1'b0;
`ifdef RELU_PACK_SAT_CNT_EN
      sat_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pack_q      <= pack_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      pend_addr_q <= pend_addr_d;
      wr_en_q     <= wr_en_d;
      wr_last_q   <= wr_last_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
`ifdef RELU_PACK_SAT_CNT_EN
      sat_cnt_q   <= sat_cnt_d;
`endif
    end
  end

  assign bus.wr_en_o    = wr_en_q;
  assign bus.wr_addr_o  = wr_addr_q;
  assign bus.wr_data_o  = wr_data_q;
  assign bus.l2_start_o = (state_q == FIRE);
  assign bus.busy_o     = busy;
  assign bus.err_o      = err_q;
`ifdef RELU_PACK_SAT_CNT_EN
  assign bus.sat_cnt_o  = sat_cnt_q;
`endif

endmodule

// File: tb/tb_layer1_relu_pack.sv
// Directed/randomized bench for layer1_relu_pack: a 64-neuron and a 10-neuron instance.
// Writes and l2 pulses are logged at negedge and compared against a per-neuron activation model.
module tb_layer1_relu_pack;
  localparam int SHIFT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  layer1_relu_pack_if #(.ACC_W(32), .ADDR_W(6)) ia ();
  layer1_relu_pack_if #(.ACC_W(32), .ADDR_W(6)) ib ();

  layer1_relu_pack u_a (.clk_i(clk), .rst_i(rst), .bus(ia));
  layer1_relu_pack #(.NUM_NEURONS(10)) u_b (.clk_i(clk), .rst_i(rst), .bus(ib));

  int tests = 0;
  int fails = 0;

  logic [5:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          l2_cyc[$];
  int          sat_q[$];
  logic [7:0]  acts[256];
  int          pulse_cyc[256];
  int          nacc = 0;
  int          nsat = 0;

  always @(negedge clk) begin
    if (ia.wr_en_o) begin
      wq_addr.push_back(ia.wr_addr_o); wq_data.push_back(ia.wr_data_o); wq_cyc.push_back(cyc);
    end
    if (ib.wr_en_o) begin
      wq_addr.push_back(ib.wr_addr_o); wq_data.push_back(ib.wr_data_o); wq_cyc.push_back(cyc);
    end
    if (ia.l2_start_o || ib.l2_start_o) begin
      l2_cyc.push_back(cyc);
`ifdef RELU_PACK_SAT_CNT_EN
      if (ia.l2_start_o) sat_q.push_back(int'(ia.sat_cnt_o));
`endif
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit b, input bit st, input bit re, input int acc);
    if (!b) begin ia.start_i = st; ia.relu_en_i = re; ia.acc_i = acc; end
    else    begin ib.start_i = st; ib.relu_en_i = re; ib.acc_i = acc; end
    @(posedge clk); #1;
    ia.start_i = 1'b0; ia.relu_en_i = 1'b0;
    ib.start_i = 1'b0; ib.relu_en_i = 1'b0;
  endtask

  // Model: clamp negatives to zero, divide by 2^SHIFT, saturate above 255.
  task automatic send(input bit b, input int acc);
    longint r;
    r = (acc < 0) ? 64'sd0 : longint'(acc) / (64'sd1 << SHIFT);
    acts[nacc] = (r > 255) ? 8'hFF : 8'(r);
    if (r > 255) nsat++;
    pulse_cyc[nacc] = cyc;
    nacc++;
    drive(b, 1'b0, 1'b1, acc);
  endtask

  task automatic clear_model();
    nacc = 0; nsat = 0;
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); l2_cyc.delete(); sat_q.delete();
  endtask

  task automatic wait_l2(input string tag, input int budget);
    int k = 0;
    while (l2_cyc.size() == 0 && k < budget) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, " l2_seen"}, l2_cyc.size(), 1);
  endtask

  task automatic check_image(input string tag, input int n);
    int nw = (n + 3) / 4;
    int lp;
    logic [31:0] ew;
    chk({tag, " nwrites"}, wq_data.size(), nw);
    for (int w = 0; w < nw && w < wq_data.size(); w++) begin
      ew = '0;
      for (int k = 0; k < 4; k++) if (4*w + k < n) ew[8*k +: 8] = acts[4*w + k];
      lp = (4*w + 3 < n) ? 4*w + 3 : n - 1;
      chk({tag, " addr"}, wq_addr[w], w);
      chk({tag, " data"}, wq_data[w], ew);
      chk({tag, " latency"}, wq_cyc[w] - pulse_cyc[lp], 2);
    end
    if (l2_cyc.size() > 0 && wq_cyc.size() > 0)
      chk({tag, " l2_after_last_wr"}, l2_cyc[0] - wq_cyc[wq_cyc.size()-1], 1);
    clear_model();
  endtask

  function automatic int rnd_acc();
    return int'($urandom_range(0, 75000)) - 5000;
  endfunction

  initial begin
    bit busy_drop;
    logic [31:0] w0, w2;

    rst = 1'b1;
    ia.start_i = 1'b0; ia.relu_en_i = 1'b0; ia.acc_i = '0;
    ib.start_i = 1'b0; ib.relu_en_i = 1'b0; ib.acc_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    chk("rst wr_en", ia.wr_en_o, 0);
    chk("rst wr_data", ia.wr_data_o, 0);
    chk("rst busy", ia.busy_o, 0);
    chk("rst err", ia.err_o, 0);
    chk("rst l2_start", ia.l2_start_o, 0);
    chk("rst busy_b", ib.busy_o, 0);

    // 64 back-to-back ramp neurons
    clear_model();
    drive(0, 1'b1, 1'b0, 0);
    chk("ramp busy", ia.busy_o, 1);
    for (int n = 0; n < 64; n++) send(0, n * 256);
    wait_l2("ramp", 20);
    chk("ramp busy_at_l2", ia.busy_o, 0);
    w0 = (wq_data.size() > 0) ? wq_data[0] : 32'h0;
    chk("ramp word0", w0, 32'h03020100);
    check_image("ramp", 64);

    // 10-neuron partial image with edge values
    drive(1, 1'b1, 1'b0, 0);
    send(1, -5);
    send(1, 32'h7FFF_FFFF);
    send(1, 300);
    for (int i = 0; i < 7; i++) send(1, rnd_acc());
    wait_l2("n10", 20);
    w0 = (wq_data.size() > 0) ? wq_data[0] : 32'h0;
    w2 = (wq_data.size() > 2) ? wq_data[2] : 32'hFFFF_FFFF;
    chk("n10 byte0_neg", w0[7:0], 8'h00);
    chk("n10 byte1_huge", w0[15:8], 8'hFF);
    chk("n10 byte2_300", w0[23:16], 8'h01);
    chk("n10 addr2_upper", w2[31:16], 16'h0000);
    check_image("n10", 10);

    // slow cadence, one neuron every 784 cycles
    busy_drop = 1'b0;
    drive(1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      send(1, rnd_acc());
      if (i < 9) repeat (783) begin
        @(posedge clk); #1;
        if (!ib.busy_o) busy_drop = 1'b1;
      end
    end
    wait_l2("slow", 20);
    chk("slow busy_held", busy_drop, 0);
    check_image("slow", 10);

    // reset part way through an image
    drive(0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 30; i++) send(0, rnd_acc());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort nwrites", wq_data.size(), 7);
    chk("abort l2", l2_cyc.size(), 0);
    chk("abort busy", ia.busy_o, 0);
    clear_model();
    drive(0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 64; i++) send(0, rnd_acc());
    wait_l2("after_abort", 20);
    check_image("after_abort", 64);

    // overrun errors
    drive(0, 1'b0, 1'b1, 1000);
    chk("err relu_idle", ia.err_o, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("err relu_idle nwrites", wq_data.size(), 0);
    chk("err relu_idle busy", ia.busy_o, 0);
    drive(0, 1'b1, 1'b0, 0);
    chk("err cleared_by_start", ia.err_o, 0);
    for (int i = 0; i < 10; i++) send(0, rnd_acc());
    drive(0, 1'b1, 1'b0, 0);
    chk("err start_busy", ia.err_o, 1);
    for (int i = 10; i < 64; i++) send(0, rnd_acc());
    wait_l2("err_img", 20);
    chk("err sticky", ia.err_o, 1);
    check_image("err_img", 64);
    drive(0, 1'b1, 1'b0, 0);
    chk("err next_start", ia.err_o, 0);

    // image with five saturating neurons
    for (int i = 0; i < 64; i++) begin
      if (i % 13 == 3) send(0, 65536 + int'($urandom_range(0, 100000)));
      else             send(0, int'($urandom_range(0, 70535)) - 5000);
    end
    wait_l2("sat", 20);
`ifdef RELU_PACK_SAT_CNT_EN
    chk("sat cnt_at_l2", (sat_q.size() > 0) ? sat_q[0] : -1, nsat);
`endif
    check_image("sat", 64);
    drive(0, 1'b1, 1'b0, 0);
`ifdef RELU_PACK_SAT_CNT_EN
    chk("sat cnt_after_start", ia.sat_cnt_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
